markov_puf_eval_ctrl: RTL and testbench
=======================================

// Module: markov_puf_eval_ctrl
// PURPOSE
//   Sequencer that drives the Markov-CBO-PUF datapath. It accepts a raw challenge
//   through a valid/ready handshake and drives it plus a K-bit feedback history
//   into the CBO obfuscation stage. It registers the obfuscated challenge, launches
//   the PUF delay chain, waits for settling, then samples the response bit. The
//   response bit is shifted into the feedback history (Markov state) for the next
//   challenge.
// PARAMETERS
//   nStage   64   challenge width; must equal the CBO nStage
//   K        2    feedback history width; must equal the CBO K (K>=1)
//   SETTLE   8    cycles waited after launch before sampling puf_response (>=1)
//   FB_INIT  0    K-bit value loaded into the history on reset and on fb_clear
// PORTS
//   clk               in   1       system clock, rising edge
//   rst_n             in   1       asynchronous active-low reset
//   chal_valid        in   1       raw challenge available
//   chal_ready        out  1       controller can accept a challenge
//   chal_in           in   nStage  raw challenge
//   cbo_challenge_in  out  nStage  raw challenge held for the CBO stage
//   cbo_feedback_in   out  K       feedback history presented to the CBO stage
//   cbo_challenge_out in   nStage  obfuscated challenge from the CBO stage (combinational)
//   puf_challenge     out  nStage  registered obfuscated challenge applied to the PUF
//   puf_launch        out  1       one-cycle launch pulse to the PUF chain
//   puf_response      in   1       PUF arbiter output; valid after SETTLE cycles
//   resp_valid        out  1       response bit available
//   resp_ready        in   1       consumer accepts the response
//   resp_bit          out  1       captured response bit
//   fb_clear          in   1       synchronous clear of the history to FB_INIT
//   eval_count        out  16      completed evaluations; wraps 0xFFFF->0
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - state=IDLE; chal_ready=1; puf_launch=0; resp_valid=0; resp_bit=0.
//     - cbo_challenge_in=0; puf_challenge=0; history=FB_INIT; eval_count=0; counter=0.
//   FSM states and transitions
//     - IDLE: chal_ready=1. On chal_valid&chal_ready, latch chal_in into
//       cbo_challenge_in and go to LOAD.
//     - LOAD: 1 cycle. puf_challenge<=cbo_challenge_out. Go to LAUNCH.
//     - LAUNCH: puf_launch=1 for exactly this cycle. Counter<=0. Go to WAIT.
//     - WAIT: counter increments each cycle. When counter==SETTLE-1, go to CAPTURE.
//     - CAPTURE: 1 cycle.
//         resp_bit<=puf_response.
//         history<={history[K-2:0],puf_response}; for K=1, history<=puf_response.
//         eval_count<=eval_count+1 (wraps). Go to OUT.
//     - OUT: resp_valid=1. resp_bit is held until resp_valid&resp_ready, then
//       return to IDLE.
//   Timing and handshakes
//     - chal_ready=1 only in IDLE; no overlap of evaluations.
//     - Latency: chal accepted on edge E0 -> puf_launch high in cycle E2.
//       The response is sampled on edge E3+SETTLE; resp_valid is high from that edge.
//     - Back-to-back: resp accepted on edge Ex -> chal_ready=1 in the next cycle.
//       The minimum period is SETTLE+5 cycles.
//   History and outputs
//     - cbo_feedback_in=history. The history changes only in CAPTURE or on
//       fb_clear, so it is stable from LOAD through WAIT.
//     - cbo_challenge_in and puf_challenge hold their values until the next accept
//       or LOAD.
//   fb_clear
//     - Accepted in any state. If it coincides with CAPTURE, the clear wins: history
//       =FB_INIT, but resp_bit and eval_count still update.
//     - If asserted during LOAD/LAUNCH/WAIT, the in-flight evaluation uses the
//       already-registered puf_challenge.
//   Mid-operation reset: the in-flight evaluation is discarded, with no resp_valid
//   and no count increment.
//   resp_ready while not in OUT is ignored.
// TESTING
//   1. Reset: rst_n low mid-WAIT -> immediately chal_ready=1, puf_launch=0,
//      resp_valid=0, cbo_feedback_in=FB_INIT, eval_count=0.
//   2. Single eval, SETTLE=8, puf_response=1, accept on edge 0 -> puf_launch high
//      only in cycle 2; resp_valid rises on edge 11; resp_bit=1; history 2'b00->2'b01.
//   3. Three evals, responses 1,0,1, resp_ready tied high -> cbo_feedback_in reads
//      00,01,10 at each LOAD; final history=2'b01; eval_count=3.
//   4. Backpressure: resp_ready low 5 cycles in OUT -> resp_valid/resp_bit stable;
//      chal_ready=0 throughout; chal_valid held high -> not accepted until after
//      the resp handshake.
//   5. fb_clear during CAPTURE with history=2'b11, puf_response=1 -> history=FB_INIT
//      (00); resp_bit=1; eval_count increments.
//   6. eval_count preloaded to 0xFFFF (via 65535 evals or force) -> the next
//      CAPTURE yields 0x0000.

Source files
------------

// File: rtl/markov_puf_eval_ctrl.sv
// Evaluation sequencer for the Markov-CBO-PUF datapath: it takes one challenge, obfuscates it
// with the feedback history, launches the PUF, waits SETTLE cycles and returns the response.
module markov_puf_eval_ctrl #(
  parameter int             nStage  = 64,
  parameter int             K       = 2,
  parameter int             SETTLE  = 8,
  parameter logic [K-1:0]   FB_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chal_valid,
  output logic              chal_ready,
  input  logic [nStage-1:0] chal_in,
  output logic [nStage-1:0] cbo_challenge_in,
  output logic [K-1:0]      cbo_feedback_in,
  input  logic [nStage-1:0] cbo_challenge_out,
  output logic [nStage-1:0] puf_challenge,
  output logic              puf_launch,
  input  logic              puf_response,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
  input  logic              fb_clear,
  output logic [15:0]       eval_count
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, WAIT, CAPTURE, OUT} state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [K-1:0]  history;
  logic [K-1:0]  history_shifted;

  // Shifting left and OR-ing in the new bit also covers K=1 without a special case.
  assign history_shifted = (history << 1) | K'(puf_response);
  assign cbo_feedback_in = history;

  // NOTE: every register below uses non-blocking assignment so all of them sample
  // the pre-edge values; a later assignment in the same edge simply overrides an earlier one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      chal_ready       <= 1'b1;
      puf_launch       <= 1'b0;
      resp_valid       <= 1'b0;
      resp_bit         <= 1'b0;
      cbo_challenge_in <= '0;
      puf_challenge    <= '0;
      history          <= FB_INIT;
      eval_count       <= '0;
      counter          <= '0;
    end else begin
      puf_launch <= 1'b0;
      case (state)
        IDLE: begin
          if (chal_valid && chal_ready) begin
            cbo_challenge_in <= chal_in;
            chal_ready       <= 1'b0;
            state            <= LOAD;
          end
        end
        LOAD: begin
          puf_challenge <= cbo_challenge_out;
          puf_launch    <= 1'b1;
          state         <= LAUNCH;
        end
        LAUNCH: begin
          counter <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (counter == CW'(SETTLE - 1)) state <= CAPTURE;
          else                            counter <= counter + 1'b1;
        end
        CAPTURE: begin
          resp_bit   <= puf_response;
          history    <= history_shifted;
          eval_count <= eval_count + 16'd1;
          resp_valid <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            chal_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          chal_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
      // Placed last so a clear coinciding with CAPTURE overrides the shift.
      if (fb_clear) history <= FB_INIT;
    end
  end

endmodule

// File: tb/tb_markov_puf_eval_ctrl.sv
// Bench for markov_puf_eval_ctrl: a table of directed evaluations, hand-written corner
// sequences and randomized evaluations checked against a bit-history/counter model.
module tb_markov_puf_eval_ctrl;

  localparam int NST    = 64;
  localparam int KW     = 2;
  localparam int SETTLE = 8;
  localparam logic [63:0] CBO_KEY = 64'hC3A5_0F1E_9B24_7D68;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            chal_valid, chal_ready;
  logic [NST-1:0]  chal_in, cbo_challenge_in, cbo_challenge_out, puf_challenge;
  logic [KW-1:0]   cbo_feedback_in;
  logic            puf_launch, puf_response;
  logic            resp_valid, resp_ready, resp_bit, fb_clear;
  logic [15:0]     eval_count;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] m_hist;
  int         m_count;

  markov_puf_eval_ctrl #(.nStage(NST), .K(KW), .SETTLE(SETTLE), .FB_INIT(2'b00)) dut (
    .clk(clk), .rst_n(rst_n),
    .chal_valid(chal_valid), .chal_ready(chal_ready), .chal_in(chal_in),
    .cbo_challenge_in(cbo_challenge_in), .cbo_feedback_in(cbo_feedback_in),
    .cbo_challenge_out(cbo_challenge_out), .puf_challenge(puf_challenge),
    .puf_launch(puf_launch), .puf_response(puf_response),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bit(resp_bit),
    .fb_clear(fb_clear), .eval_count(eval_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] cbo_model(input logic [63:0] c, input logic [1:0] fb);
    return c ^ {32{fb}} ^ CBO_KEY;
  endfunction

  // Stand-in for the combinational CBO stage.
  always_comb cbo_challenge_out = cbo_model(cbo_challenge_in, cbo_feedback_in);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One complete evaluation, entered and left at a negedge in IDLE. The PUF output is
  // driven to the wrong value everywhere except the cycle in which it must be sampled.
  task automatic do_eval(input logic [63:0] chal, input logic resp, input int stall,
                         input logic clr_cap, input logic clr_wait, input logic hold_valid,
                         output logic [1:0] fb_load, output logic [1:0] hist_after);
    logic [63:0] exp_pc;
    check("chal_ready_idle", chal_ready, 1);
    chal_valid   = 1'b1;
    chal_in      = chal;
    puf_response = ~resp;
    @(posedge clk);
    @(negedge clk);
    chal_valid = 1'b0;
    chal_in    = {$urandom, $urandom};
    fb_load    = cbo_feedback_in;
    check("chal_ready_load", chal_ready, 0);
    check("cbo_challenge_in", cbo_challenge_in, chal);
    check("fb_at_load", cbo_feedback_in, m_hist);
    check("launch_in_load", puf_launch, 0);
    exp_pc = cbo_model(chal, m_hist);
    @(negedge clk);
    check("launch_pulse", puf_launch, 1);
    check("puf_challenge", puf_challenge, exp_pc);
    for (int c = 2; c <= SETTLE + 1; c++) begin
      @(negedge clk);
      check("launch_after", puf_launch, 0);
      check("resp_valid_wait", resp_valid, 0);
      resp_ready = 1'($urandom_range(0, 1));
      fb_clear   = 1'b0;
      if (clr_wait && c == 3) begin
        fb_clear = 1'b1;
        m_hist   = 2'b00;
      end
    end
    @(negedge clk);
    check("resp_valid_capture", resp_valid, 0);
    check("puf_challenge_held", puf_challenge, exp_pc);
    puf_response = resp;
    fb_clear     = clr_cap;
    resp_ready   = 1'b0;
    @(negedge clk);
    puf_response = ~resp;
    fb_clear     = 1'b0;
    m_hist       = clr_cap ? 2'b00 : {m_hist[0], resp};
    m_count      = (m_count + 1) % 65536;
    hist_after   = cbo_feedback_in;
    check("resp_valid_out", resp_valid, 1);
    check("resp_bit", resp_bit, resp);
    check("eval_count", eval_count, 64'(m_count));
    check("history", cbo_feedback_in, m_hist);
    chal_valid = hold_valid;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_resp_valid", resp_valid, 1);
      check("stall_resp_bit", resp_bit, resp);
      check("stall_chal_ready", chal_ready, 0);
      check("stall_no_accept", cbo_challenge_in, chal);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chal_valid = 1'b0;
    check("resp_valid_done", resp_valid, 0);
    check("chal_ready_done", chal_ready, 1);
    check("no_accept_in_out", cbo_challenge_in, chal);
    check("count_held", eval_count, 64'(m_count));
  endtask

  typedef struct {
    logic [63:0] chal;
    logic        resp;
    int          stall;
    logic        clr_cap;
    logic        hold_valid;
    logic [1:0]  exp_fb_load;
    logic [1:0]  exp_hist;
    logic [15:0] exp_count;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [1:0] fbl, hst;
    tbl[0] = '{64'h0123_4567_89AB_CDEF, 1'b1, 0, 1'b0, 1'b0, 2'b00, 2'b01, 16'd1};
    tbl[1] = '{64'hFFFF_0000_FFFF_0000, 1'b0, 0, 1'b0, 1'b0, 2'b01, 2'b10, 16'd2};
    tbl[2] = '{64'hDEAD_BEEF_CAFE_F00D, 1'b1, 0, 1'b0, 1'b0, 2'b10, 2'b01, 16'd3};
    tbl[3] = '{64'h5555_AAAA_5555_AAAA, 1'b1, 5, 1'b0, 1'b1, 2'b01, 2'b11, 16'd4};
    tbl[4] = '{64'h8000_0000_0000_0001, 1'b1, 1, 1'b1, 1'b0, 2'b11, 2'b00, 16'd5};
    tbl[5] = '{64'h0000_0000_0000_0000, 1'b0, 2, 1'b0, 1'b1, 2'b00, 2'b00, 16'd6};

    rst_n = 1'b0; chal_valid = 1'b0; chal_in = '0; puf_response = 1'b0;
    resp_ready = 1'b0; fb_clear = 1'b0;
    m_hist = 2'b00; m_count = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_chal_ready", chal_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_launch", puf_launch, 0);
    check("rst_resp_bit", resp_bit, 0);
    check("rst_history", cbo_feedback_in, 0);
    check("rst_count", eval_count, 0);
    check("rst_cbo_chal", cbo_challenge_in, 0);
    check("rst_puf_chal", puf_challenge, 0);

    for (int i = 0; i < 6; i++) begin
      do_eval(tbl[i].chal, tbl[i].resp, tbl[i].stall, tbl[i].clr_cap, 1'b0,
              tbl[i].hold_valid, fbl, hst);
      check("tbl_fb_load", fbl, tbl[i].exp_fb_load);
      check("tbl_hist", hst, tbl[i].exp_hist);
      check("tbl_count", eval_count, tbl[i].exp_count);
    end

    // resp_ready outside OUT is ignored.
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    resp_ready = 1'b0;
    check("idle_ready_valid", resp_valid, 0);
    check("idle_ready_count", eval_count, 64'(m_count));
    check("idle_chal_ready", chal_ready, 1);

    // Reset asserted mid-WAIT discards the evaluation immediately.
    do_eval(64'h1111_2222_3333_4444, 1'b1, 0, 1'b0, 1'b0, 1'b0, fbl, hst);
    chal_valid = 1'b1; chal_in = 64'hABCD;
    @(posedge clk);
    @(negedge clk);
    chal_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_chal_ready", chal_ready, 1);
    check("mid_rst_launch", puf_launch, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_history", cbo_feedback_in, 0);
    check("mid_rst_count", eval_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hist = 2'b00; m_count = 0;
    @(negedge clk);
    check("post_rst_count", eval_count, 0);

    // eval_count wrap from 0xFFFF.
    force dut.eval_count = 16'hFFFF;
    @(negedge clk);
    release dut.eval_count;
    @(negedge clk);
    check("preload_count", eval_count, 16'hFFFF);
    m_count = 65535;
    do_eval(64'h0F0F_0F0F_F0F0_F0F0, 1'b0, 0, 1'b0, 1'b0, 1'b0, fbl, hst);
    check("wrap_count", eval_count, 0);

    // Randomized evaluations against the model.
    for (int n = 0; n < 40; n++) begin
      logic cc, cw;
      cc = ($urandom_range(0, 7) == 0);
      cw = !cc && ($urandom_range(0, 7) == 0);
      do_eval({$urandom, $urandom}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              cc, cw, 1'($urandom_range(0, 1)), fbl, hst);
    end

    // fb_clear in IDLE.
    m_hist = 2'b00;
    fb_clear = 1'b1;
    @(negedge clk);
    fb_clear = 1'b0;
    check("idle_clear", cbo_feedback_in, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
